// File: rtl/debug_priv_unlock_ctrl_if.sv
// rtl/debug_priv_unlock_ctrl_if.sv - password handshake channel into the privilege unlock controller
interface debug_priv_unlock_ctrl_if #(
    parameter int PW_W = 32
);
    logic            pw_valid;
    logic [PW_W-1:0] pw_data;
    logic            pw_ready;

    modport master (output pw_valid, output pw_data, input pw_ready);
    modport slave  (input pw_valid, input pw_data, output pw_ready);
endinterface

// File: rtl/debug_priv_unlock_ctrl.sv
// rtl/debug_priv_unlock_ctrl.sv - password-gated machine-privilege grant for a debug requester
module debug_priv_unlock_ctrl #(
    parameter int PW_W           = 32,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int SESSION_CYCLES = 65536,
    localparam int FC_W          = $clog2(MAX_FAIL + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    debug_req,
    input  logic [1:0]              usr_mode,
    debug_priv_unlock_ctrl_if.slave pw,
    input  logic [PW_W-1:0]         fuse_pw,
    output logic [1:0]              mode_o,
    output logic                    unlocked_o,
    output logic                    lockout_o,
    output logic [FC_W-1:0]         fail_cnt_o
);

    localparam int TMR_MAX = (SESSION_CYCLES > LOCKOUT_CYCLES) ? SESSION_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SESSION_LOAD = TMR_W'(SESSION_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FAIL_LIMIT   = FC_W'(MAX_FAIL);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [FC_W-1:0]   fail_cnt, fail_nxt, fail_inc;
    logic [TMR_W-1:0]  timer, timer_nxt, timer_dec;
    logic [PW_W-1:0]   cap_pw, cap_nxt;
    logic [1:0]        mode_nxt, usr_clean;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOCKED;
            fail_cnt <= '0;
            timer    <= '0;
            cap_pw   <= '0;
            mode_o   <= 2'b00;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
            timer    <= timer_nxt;
            cap_pw   <= cap_nxt;
            mode_o   <= mode_nxt;
        end
    end

    // Timer and fail count both clamp instead of wrapping.
    assign timer_dec = (timer != '0) ? timer - 1'b1 : timer;
    assign fail_inc  = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        timer_nxt = timer;
        cap_nxt   = cap_pw;
        case (state)
            ST_LOCKED: begin
                if (pw.pw_valid) begin
                    cap_nxt   = pw.pw_data;
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cap_nxt = '0;
                if (cap_pw == fuse_pw) begin
                    state_nxt = ST_UNLOCKED;
                    fail_nxt  = '0;
                    timer_nxt = SESSION_LOAD;
                end else begin
                    fail_nxt = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_nxt = ST_LOCKOUT;
                        timer_nxt = LOCKOUT_LOAD;
                    end else begin
                        state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_UNLOCKED: begin
                timer_nxt = timer_dec;
                if (!debug_req || timer == '0) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                timer_nxt = timer_dec;
                if (timer == '0) begin
                    state_nxt = ST_LOCKED;
                    fail_nxt  = '0;
                end
            end
            default: state_nxt = ST_LOCKED;
        endcase
    end

    // Reserved privilege encoding 2'b10 is never passed to the core.
    assign usr_clean = (usr_mode == 2'b10) ? 2'b00 : usr_mode;
    assign mode_nxt  = (state == ST_UNLOCKED && debug_req) ? 2'b11 : usr_clean;

    assign pw.pw_ready = (state == ST_LOCKED);
    assign unlocked_o  = (state == ST_UNLOCKED);
    assign lockout_o   = (state == ST_LOCKOUT);
    assign fail_cnt_o  = fail_cnt;

endmodule
